// File: rtl/imm_extend_queue.sv
// Immediate decoder/extender feeding a DEPTH-entry FIFO of
// {ImmExt, OutTag, IllegalImm}, decoupling fetch from decode stalls.
module imm_extend_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] OutTag,
  output logic             IllegalImm,
  output logic [CW-1:0]    Count
);

  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             ill_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      raw;
  logic             sx;
  logic             ill_d;
  logic [XLEN-1:0]  imm_d;
  logic             full, empty, push, pop;

  always_comb begin
    raw   = '0;
    sx    = 1'b0;
    ill_d = 1'b0;
    unique case (ImmSrc)
      3'b000: begin
        raw = {{20{Instr[31]}}, Instr[31:20]};
        sx  = 1'b1;
      end
      3'b001: begin
        raw = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
        sx  = 1'b1;
      end
      3'b010: begin
        raw = {{19{Instr[31]}}, Instr[31], Instr[7],
               Instr[30:25], Instr[11:8], 1'b0};
        sx  = 1'b1;
      end
      3'b011: begin
        raw = {{11{Instr[31]}}, Instr[31], Instr[19:12],
               Instr[20], Instr[30:21], 1'b0};
        sx  = 1'b1;
      end
      3'b100: begin
        raw = {Instr[31:12], 12'b0};
        sx  = 1'b1;
      end
      3'b101: begin
        // RV64 shifts use a 6-bit shamt
        if (XLEN == 64) raw = {26'b0, Instr[25:20]};
        else            raw = {27'b0, Instr[24:20]};
      end
      3'b110: raw = {27'b0, Instr[19:15]};
      default: ill_d = 1'b1;
    endcase
    imm_d = sx ? XLEN'($signed(raw)) : XLEN'(raw);
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign InReady  = !full;
  assign OutValid = !empty;
  assign push     = InValid && !full;
  assign pop      = !empty && OutReady;
  assign Count    = cnt_q;

  assign ImmExt     = empty ? '0   : imm_q[rd_q];
  assign OutTag     = empty ? '0   : tag_q[rd_q];
  assign IllegalImm = empty ? 1'b0 : ill_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
        ill_q[i] <= 1'b0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        imm_q[wr_q] <= imm_d;
        tag_q[wr_q] <= InTag;
        ill_q[wr_q] <= ill_d;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule
